// File: rtl/dcache_sram_nway.sv
// N-way set-associative data-cache array with true-LRU replacement and a sequential flush.
// Optional hit/miss statistics counters are enabled with DCACHE_SRAM_NWAY_STATS_EN.
module dcache_sram_nway #(
  parameter int WAYS   = 4,
  parameter int SETS   = 16,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [$clog2(SETS)-1:0] addr_i,
  input  logic [TAG_W+1:0]        tag_i,
  input  logic [LINE_W-1:0]       data_i,
  input  logic                    enable_i,
  input  logic                    write_i,
  output logic [TAG_W+1:0]        tag_o,
  output logic [LINE_W-1:0]       data_o,
  output logic                    hit_o,
  input  logic                    flush_i,
  output logic                    busy_o,
  output logic [31:0]             hit_cnt_o,
  output logic [31:0]             miss_cnt_o
);

  localparam int IDX_W = $clog2(SETS);
  localparam int AGE_W = $clog2(WAYS);
  localparam int TW    = TAG_W + 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [TW-1:0]     tag_q  [SETS][WAYS];
  logic [LINE_W-1:0] data_q [SETS][WAYS];
  logic [AGE_W-1:0]  age_q  [SETS][WAYS];

  logic [0:0]       state_q;
  logic [IDX_W-1:0] flush_idx_q;

  logic             access;
  logic             hit_any;
  logic [AGE_W-1:0] hit_way;
  logic             inv_found;
  logic [AGE_W-1:0] inv_way;
  logic [AGE_W-1:0] lru_way;
  logic [AGE_W-1:0] victim_way;
  logic             hit;
  logic             touch;
  logic [AGE_W-1:0] touch_way;
  logic [AGE_W-1:0] touch_age;

  // The request's valid bit carries no meaning on lookup or fill.
  logic unused_req_valid;
  assign unused_req_valid = tag_i[TAG_W+1];

  assign busy_o = (state_q == ST_FLUSH);
  assign access = enable_i && !busy_o;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    hit_any   = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (tag_q[addr_i][w][TW-1] && (tag_q[addr_i][w][TAG_W-1:0] == tag_i[TAG_W-1:0])) begin
        hit_any = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (age_q[addr_i][w] == AGE_W'(WAYS - 1)) lru_way = AGE_W'(w);
    end
    // Descending scan so the lowest-index invalid way is the one left standing.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!tag_q[addr_i][w][TW-1]) begin
        inv_found = 1'b1;
        inv_way   = AGE_W'(w);
      end
    end
    victim_way = inv_found ? inv_way : lru_way;
    hit        = access && hit_any;
    touch      = access && (hit_any || write_i);
    touch_way  = hit_any ? hit_way : victim_way;
    touch_age  = age_q[addr_i][touch_way];
  end

  always_comb begin
    hit_o  = 1'b0;
    tag_o  = '0;
    data_o = '0;
    if (access) begin
      if (hit_any) begin
        hit_o  = 1'b1;
        tag_o  = tag_q[addr_i][hit_way];
        data_o = data_q[addr_i][hit_way];
      end else if (!inv_found) begin
        tag_o  = tag_q[addr_i][victim_way];
        data_o = data_q[addr_i][victim_way];
      end
    end
  end

  // NOTE: the whole array, data included, is reset so the cache starts empty and clean with deterministic
  // contents; this keeps the arrays in flops rather than a reset-less SRAM macro.
  // NOTE: sequential state uses non-blocking assignments only, so all registers update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      flush_idx_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]  <= '0;
          data_q[s][w] <= '0;
          age_q[s][w]  <= AGE_W'(w);
        end
      end
    end else if (state_q == ST_FLUSH) begin
      for (int w = 0; w < WAYS; w++) begin
        tag_q[flush_idx_q][w][TW-1 -: 2] <= 2'b00;
        age_q[flush_idx_q][w]            <= AGE_W'(w);
      end
      flush_idx_q <= flush_idx_q + 1'b1;
      if (flush_idx_q == IDX_W'(SETS - 1)) state_q <= ST_IDLE;
    end else begin
      if (touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_W'(w) == touch_way) begin
            age_q[addr_i][w] <= '0;
          end else if (age_q[addr_i][w] < touch_age) begin
            age_q[addr_i][w] <= age_q[addr_i][w] + 1'b1;
          end
        end
        if (write_i) begin
          data_q[addr_i][touch_way] <= data_i;
          if (hit_any) begin
            tag_q[addr_i][touch_way][TW-1 -: 2] <= 2'b11;
          end else begin
            tag_q[addr_i][touch_way] <= {1'b1, tag_i[TAG_W], tag_i[TAG_W-1:0]};
          end
        end
      end
      if (flush_i) begin
        state_q     <= ST_FLUSH;
        flush_idx_q <= '0;
      end
    end
  end

`ifdef DCACHE_SRAM_NWAY_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (access) begin
      if (hit) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: doc/dcache_sram_nway.md
DCACHE_SRAM_NWAY -- requirements
Module: dcache_sram_nway

Interface
REQ-001 SHALL have parameter WAYS, default 4, associativity; power of 2, at least 2.
REQ-002 SHALL have parameter SETS, default 16, number of sets; power of 2; IDX_W = clog2(SETS).
REQ-003 SHALL have parameter TAG_W, default 23, address-tag bits; stored tag word is TAG_W+2 bits: [TAG_W+1] valid, [TAG_W] dirty.
REQ-004 SHALL have parameter LINE_W, default 256, line width in bits.
REQ-005 SHALL have one clock and a synchronous, active-low reset: clk_i input 1 (rising-edge clock), then rst_i input 1 (synchronous reset, active-low).
REQ-006 SHALL have ports: addr_i in IDX_W set index; tag_i in TAG_W+2 request tag (dirty bit used on fill); data_i in LINE_W write line; enable_i in 1 access request; write_i in 1 write qualifier.
REQ-007 SHALL have ports: tag_o out TAG_W+2 hit or victim tag; data_o out LINE_W hit or victim line; hit_o out 1 lookup hit; flush_i in 1 invalidate-all request; busy_o out 1 flush in progress; hit_cnt_o out 32 hit count; miss_cnt_o out 32 miss count.

Function
REQ-008 SHALL treat way w as hit when stored valid=1 and stored tag[TAG_W-1:0] == tag_i[TAG_W-1:0]; at most one way hits.
REQ-009 SHALL compute hit_o, tag_o and data_o combinationally in the same cycle as enable_i; all three are 0 when enable_i=0 or busy_o=1.
REQ-010 SHALL hold per-set true-LRU ages, log2(WAYS) bits per way, all distinct within a set.
REQ-011 SHALL select the victim as the lowest-index invalid way if any exists, otherwise the way with age WAYS-1.
REQ-012 SHALL, on a miss, drive tag_o/data_o from the victim when the victim is valid, otherwise 0.
REQ-013 SHALL, on enable_i=1 and write_i=1 with a hit, write data_i to the hit way and set valid=1, dirty=1 at the clock edge.
REQ-014 SHALL, on enable_i=1 and write_i=1 with a miss, write data_i to the victim with valid=1, dirty=tag_i[TAG_W], tag=tag_i[TAG_W-1:0].
REQ-015 SHALL, on any enabled access that hits or writes, set the touched way's age to 0 and increment every way in the set whose age was below the touched way's old age.
REQ-016 SHALL leave data, tags and ages unchanged on a read miss.
REQ-017 SHALL use a state machine IDLE -> FLUSH -> IDLE; flush_i=1 in IDLE enters FLUSH at the next edge; flush_i is ignored in FLUSH.
REQ-018 SHALL, in FLUSH, clear valid and dirty of all ways of one set per cycle, ascending from set 0, and reset its ages to way index; data is kept.
REQ-019 SHALL assert busy_o for exactly SETS cycles after flush acceptance and return to IDLE after set SETS-1 is cleared.
REQ-020 SHALL ignore enable_i while busy_o=1: no state update, no counting.
REQ-021 SHALL, on flush_i and enable_i together in IDLE, perform the access in that cycle and start the flush at the next edge.

Reset
REQ-022 SHALL, while rst_i=0 at a clock edge, clear all valid/dirty/tag/data bits, set ages to way index, enter IDLE and zero both counters.
REQ-023 SHALL have busy_o=0, hit_o=0, tag_o=0, data_o=0, hit_cnt_o=0, miss_cnt_o=0 after reset; reset during FLUSH aborts the flush.

Configuration
REQ-024 SHALL, with DCACHE_SRAM_NWAY_STATS_EN defined, increment hit_cnt_o on every enabled non-busy hit and miss_cnt_o on every enabled non-busy miss, each saturating at 0xFFFFFFFF.
REQ-025 SHALL, without DCACHE_SRAM_NWAY_STATS_EN, keep the counter ports present and tie them to constant 0 with no counter registers.

Verification (WAYS=4, SETS=16, TAG_W=23, LINE_W=256, STATS_EN defined)
REQ-026 SHALL cover this case: after reset, write misses to set 3 with tags 0x1,0x2,0x3,0x4 -> ways 0..3 filled in order, each dirty bit equal to tag_i[23].
REQ-027 SHALL cover this case: then read tag 0x1, then write-miss tag 0x5 into set 3 -> hit_o=1 on the read; the miss presents the tag 0x2 line on tag_o/data_o, and tag 0x5 replaces way 1.
REQ-028 SHALL cover this case: write hit on tag 0x3 in set 3 with data 0xAA..AA -> next read returns 0xAA..AA, tag_o[24:23]=2'b11.
REQ-029 SHALL cover this case: flush_i pulse -> busy_o high exactly 16 cycles; enable_i ignored meanwhile; afterwards all reads miss with tag_o=0.
REQ-030 SHALL cover this case: rst_i=0 asserted at flush cycle 5 -> busy_o=0 next cycle, counters 0.
REQ-031 SHALL cover this case: force hit_cnt_o to 0xFFFFFFFE, then two hits -> hit_cnt_o holds at 0xFFFFFFFF.
